// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_HATA   = 2'd1,
    FC_BAD_PC = 2'd2,
    FC_WDOG   = 2'd3
  } fault_code_t;

  // Instruction handed to the core whenever no valid fetch is possible.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Saturating 32-bit increment used by the run-cycle counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/imem_boot_controller_if.sv
// Host load stream plus core fetch/supervision signals of the boot controller.
interface imem_boot_controller_if;
  logic        host_valid;
  logic        host_ready;
  logic [31:0] host_data;
  logic        host_last;
  logic [31:0] pc;
  logic        hata;
  logic [31:0] komut;
  logic        cpu_reset;

  // Host and core side (drives the stream, pc and error flag).
  modport master (
    output host_valid, host_data, host_last, pc, hata,
    input  host_ready, komut, cpu_reset
  );

  // Controller side.
  modport slave (
    input  host_valid, host_data, host_last, pc, hata,
    output host_ready, komut, cpu_reset
  );
endinterface

// File: rtl/imem_dp.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Contents survive reset on purpose so a resident program is not lost.
module imem_dp #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Program words arrive from the host during a load.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_controller.sv
// Boot controller: loads the instruction memory from a host stream, holds the
// core in reset while not running, serves fetches and supervises each run.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for load_start, or run_start once a program is resident
// LOAD    | accepting host words into memory
// RUN     | core out of reset, fetches served, exit conditions watched
// DONE    | run ended by halt detection, results held
// FAULT   | run ended by hata, bad pc or watchdog, results held
module imem_boot_controller
  import imem_boot_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int MAX_CYCLES  = 4096,
  parameter int HALT_REPEAT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  run_start,
  imem_boot_controller_if.slave bus,
  output logic                  loaded,
  output logic                  done,
  output logic                  fault,
  output logic [1:0]            fault_code,
  output logic [31:0]           cycle_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(HALT_REPEAT + 1);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_RUN   = ST_RUN;
  localparam logic [2:0] S_DONE  = ST_DONE;
  localparam logic [2:0] S_FAULT = ST_FAULT;

  logic [2:0]    state_q, state_d;
  logic [AW:0]   load_cnt_q, load_cnt_d;
  logic          loaded_q, loaded_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  fault_code_t   fc_q, fc_d;
  logic [31:0]   cyc_q, cyc_d;
  logic [31:0]   pc_q, pc_d;
  logic          pc_vld_q, pc_vld_d;
  logic [SW-1:0] same_q, same_d;

  logic        wr_en;
  logic        last_wr;
  logic        pc_bad;
  logic        pc_match;
  logic        at_wdog;
  logic        at_halt;
  logic        can_start;
  logic        go_load;
  logic        go_run;
  logic [31:0] rdata;

  // A word is taken whenever the host offers one during LOAD; the write that
  // carries host_last or fills the last slot closes the load.
  assign wr_en   = (state_q == S_LOAD) && bus.host_valid;
  assign last_wr = wr_en && (bus.host_last || (load_cnt_q == (AW+1)'(DEPTH - 1)));

  assign pc_bad   = (bus.pc[1:0] != 2'b00) || (bus.pc[31:AW+2] != '0);
  assign pc_match = pc_vld_q && (bus.pc == pc_q);
  assign at_wdog  = (cyc_q == 32'(MAX_CYCLES - 1));
  assign at_halt  = pc_match && (same_q == SW'(HALT_REPEAT - 1));

  // load_start beats run_start when both arrive in the same cycle.
  assign can_start = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAULT);
  assign go_load   = can_start && load_start;
  assign go_run    = can_start && !load_start && run_start &&
                     ((state_q != S_IDLE) || loaded_q);

  imem_dp #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en && !reset),
    .waddr (load_cnt_q[AW-1:0]),
    .wdata (bus.host_data),
    .raddr (bus.pc[AW+1:2]),
    .rdata (rdata)
  );

  // Next-state logic: load sequencing, run supervision and exit priority.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    loaded_d   = loaded_q;
    done_d     = done_q;
    fault_d    = fault_q;
    fc_d       = fc_q;
    cyc_d      = cyc_q;
    pc_d       = pc_q;
    pc_vld_d   = pc_vld_q;
    same_d     = same_q;

    if (go_load) begin
      state_d    = S_LOAD;
      load_cnt_d = '0;
      loaded_d   = 1'b0;
      done_d     = 1'b0;
      fault_d    = 1'b0;
      fc_d       = FC_NONE;
    end else if (go_run) begin
      state_d  = S_RUN;
      cyc_d    = '0;
      same_d   = '0;
      pc_vld_d = 1'b0;
      done_d   = 1'b0;
      fault_d  = 1'b0;
      fc_d     = FC_NONE;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (wr_en) load_cnt_d = load_cnt_q + (AW+1)'(1);
          if (last_wr) begin
            state_d  = S_IDLE;
            loaded_d = 1'b1;
          end
        end
        S_RUN: begin
          pc_d     = bus.pc;
          pc_vld_d = 1'b1;
          same_d   = pc_match ? same_q + SW'(1) : '0;
          if (bus.hata) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            fc_d    = FC_HATA;
          end else if (pc_bad) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            fc_d    = FC_BAD_PC;
          end else if (at_wdog) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            fc_d    = FC_WDOG;
          end else if (at_halt) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            // The count freezes on the exit cycle so it reports where the run stopped.
            cyc_d = sat_inc32(cyc_q);
          end
        end
        S_IDLE, S_DONE, S_FAULT: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and counter registers; memory is deliberately outside this reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      load_cnt_q <= '0;
      loaded_q   <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
      fc_q       <= FC_NONE;
      cyc_q      <= '0;
      pc_q       <= '0;
      pc_vld_q   <= 1'b0;
      same_q     <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      loaded_q   <= loaded_d;
      done_q     <= done_d;
      fault_q    <= fault_d;
      fc_q       <= fc_d;
      cyc_q      <= cyc_d;
      pc_q       <= pc_d;
      pc_vld_q   <= pc_vld_d;
      same_q     <= same_d;
    end
  end

  assign bus.host_ready = (state_q == S_LOAD);
  assign bus.cpu_reset  = (state_q != S_RUN);
  assign bus.komut      = ((state_q == S_RUN) && !pc_bad) ? rdata : NOP_INSTR;

  assign loaded      = loaded_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign fault_code  = fc_q;
  assign cycle_count = cyc_q;

endmodule

// File: tb/tb_imem_boot_controller.sv
// Bench for imem_boot_controller: random programs and pc traces against a
// trace-level reference model of the load and run rules.
module tb_imem_boot_controller;
  import imem_boot_pkg::*;

  localparam int DEPTH = 64;
  localparam int MAXC  = 16;
  localparam int HREP  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        run_start;
  logic        loaded;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] cycle_count;

  imem_boot_controller_if bus();

  imem_boot_controller #(
    .DEPTH(DEPTH), .MAX_CYCLES(MAXC), .HALT_REPEAT(HREP)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .run_start(run_start),
    .bus(bus.slave), .loaded(loaded), .done(done), .fault(fault),
    .fault_code(fault_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  bit          loaded_m;
  logic [31:0] pc_tr [MAXC];
  bit          hata_tr [MAXC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scan the trace with the exit rules: first cycle where hata, a bad pc,
  // the watchdog limit or HREP repeats of the same pc happens. code 0 = done.
  function automatic void model_exit(output int t_exit, output int code);
    int run;
    run = 0;
    t_exit = MAXC - 1;
    code = 3;
    for (int t = 0; t < MAXC; t++) begin
      if (t > 0 && pc_tr[t] == pc_tr[t-1]) run++; else run = 0;
      if (hata_tr[t]) begin t_exit = t; code = 1; return; end
      if (pc_tr[t][1:0] != 2'b00 || pc_tr[t] >= 32'(4*DEPTH)) begin t_exit = t; code = 2; return; end
      if (t == MAXC - 1) begin t_exit = t; code = 3; return; end
      if (run >= HREP) begin t_exit = t; code = 0; return; end
    end
  endfunction

  task automatic load_words(input int offered, input int last_at, input string tag);
    int limit;
    logic [31:0] w;
    bit exp_rdy;
    limit = (last_at >= 0 && last_at < DEPTH) ? last_at + 1 : DEPTH;
    step();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    loaded_m = 1'b0;
    total++;
    if (loaded !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL %s entry flags: loaded/done/fault=%b%b%b want 000", tag, loaded, done, fault);
    end
    for (int i = 0; i < offered; i++) begin
      w = $urandom;
      bus.host_valid = 1'b1;
      bus.host_data  = w;
      bus.host_last  = (i == last_at);
      #1;
      exp_rdy = (i < limit);
      total++;
      if (bus.host_ready !== exp_rdy || bus.cpu_reset !== 1'b1) begin
        bad++;
        $display("FAIL %s word %0d: host_ready=%b cpu_reset=%b want %b 1", tag, i, bus.host_ready, bus.cpu_reset, exp_rdy);
      end
      if (exp_rdy) begin
        mem_m[i] = w;
        known_m[i] = 1'b1;
      end
      step();
    end
    bus.host_valid = 1'b0;
    bus.host_last  = 1'b0;
    if (offered >= limit) loaded_m = 1'b1;
    #1;
    total++;
    if (loaded !== loaded_m || bus.host_ready !== !loaded_m) begin
      bad++;
      $display("FAIL %s end: loaded=%b host_ready=%b want %b %b", tag, loaded, bus.host_ready, loaded_m, !loaded_m);
    end
  endtask

  task automatic run_trace(input string tag);
    int te, code, idx;
    logic [31:0] exp_k;
    model_exit(te, code);
    step();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    for (int t = 0; t <= te; t++) begin
      bus.pc   = pc_tr[t];
      bus.hata = hata_tr[t];
      #1;
      total++;
      if (bus.cpu_reset !== 1'b0 || cycle_count !== 32'(t)) begin
        bad++;
        $display("FAIL %s cycle %0d: cpu_reset=%b cycle_count=%0d want 0 %0d", tag, t, bus.cpu_reset, cycle_count, t);
      end
      idx = int'(pc_tr[t] >> 2);
      if (pc_tr[t][1:0] != 2'b00 || idx >= DEPTH) begin
        total++;
        if (bus.komut !== NOP_INSTR) begin
          bad++;
          $display("FAIL %s komut bad pc %h: got %h want %h", tag, pc_tr[t], bus.komut, NOP_INSTR);
        end
      end else if (known_m[idx]) begin
        exp_k = mem_m[idx];
        total++;
        if (bus.komut !== exp_k) begin
          bad++;
          $display("FAIL %s komut pc %h: got %h want %h", tag, pc_tr[t], bus.komut, exp_k);
        end
      end
      step();
    end
    bus.hata = 1'b0;
    bus.pc   = 32'h0000_0040;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (done !== (code == 0) || fault !== (code != 0) || fault_code !== 2'(code) ||
          cycle_count !== 32'(te) || bus.cpu_reset !== 1'b1) begin
        bad++;
        $display("FAIL %s exit+%0d: done=%b fault=%b code=%0d cyc=%0d rst=%b want %b %b %0d %0d 1",
                 tag, k, done, fault, fault_code, cycle_count, bus.cpu_reset,
                 (code == 0), (code != 0), code, te);
      end
      bus.pc = bus.pc + 32'd4;
      step();
    end
  endtask

  task automatic clear_trace();
    for (int t = 0; t < MAXC; t++) begin
      pc_tr[t] = 32'(4 * t);
      hata_tr[t] = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_start = 1'b0;
    run_start = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_data = '0;
    bus.host_last = 1'b0;
    bus.pc = '0;
    bus.hata = 1'b0;
    repeat (3) step();
    total++;
    if (bus.cpu_reset !== 1'b1 || bus.host_ready !== 1'b0 || loaded !== 1'b0 || done !== 1'b0 ||
        fault !== 1'b0 || fault_code !== 2'd0 || cycle_count !== 32'd0 || bus.komut !== NOP_INSTR) begin
      bad++;
      $display("FAIL reset: rst=%b rdy=%b ld=%b dn=%b flt=%b code=%0d cyc=%0d komut=%h want 1 0 0 0 0 0 0 0",
               bus.cpu_reset, bus.host_ready, loaded, done, fault, fault_code, cycle_count, bus.komut);
    end
    reset = 1'b0;
    loaded_m = 1'b0;
    for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;
  endtask

  task automatic test_full_load();
    load_words(70, -1, "full_load");
  endtask

  task automatic test_short_load();
    load_words(3, 2, "short_load");
    clear_trace();
    for (int t = 0; t < MAXC; t++) pc_tr[t] = (t < 3) ? 32'(4 * t) : 32'd8;
    run_trace("short_run");
  endtask

  task automatic test_halt();
    int b, l;
    for (int it = 0; it < 3; it++) begin
      b = $urandom_range(0, 40);
      l = $urandom_range(0, 8);
      clear_trace();
      for (int t = 0; t < MAXC; t++) pc_tr[t] = 32'(4 * (b + ((t < l) ? t : l)));
      run_trace("halt");
    end
  endtask

  task automatic test_hata();
    int k;
    clear_trace();
    hata_tr[10] = 1'b1;
    run_trace("hata10");
    clear_trace();
    k = $urandom_range(2, 12);
    hata_tr[k] = 1'b1;
    pc_tr[k] = 32'h0000_0104;
    run_trace("hata_over_badpc");
  endtask

  task automatic test_bad_pc();
    int k;
    clear_trace();
    pc_tr[5] = 32'h0000_0104;
    run_trace("badpc_range");
    clear_trace();
    k = $urandom_range(1, 13);
    pc_tr[k] = pc_tr[k] + 32'd2;
    run_trace("badpc_align");
  endtask

  task automatic test_watchdog();
    clear_trace();
    for (int t = 0; t < MAXC; t++) pc_tr[t] = 32'(4 * (48 + t));
    run_trace("watchdog");
    clear_trace();
    for (int t = 0; t < MAXC; t++) pc_tr[t] = 32'(4 * ($urandom_range(0, 1) + 3 * t));
    run_trace("rerun");
  endtask

  task automatic test_load_wins();
    step();
    load_start = 1'b1;
    run_start = 1'b1;
    step();
    load_start = 1'b0;
    run_start = 1'b0;
    total++;
    if (bus.host_ready !== 1'b1 || bus.cpu_reset !== 1'b1 || fault !== 1'b0 || loaded !== 1'b0) begin
      bad++;
      $display("FAIL load_wins: rdy=%b rst=%b fault=%b loaded=%b want 1 1 0 0",
               bus.host_ready, bus.cpu_reset, fault, loaded);
    end
    load_words(5, 4, "after_both");
  endtask

  task automatic test_reset_mid_load();
    load_words(10, -1, "partial");
    reset = 1'b1;
    step();
    reset = 1'b0;
    loaded_m = 1'b0;
    total++;
    if (loaded !== 1'b0 || bus.host_ready !== 1'b0 || bus.cpu_reset !== 1'b1) begin
      bad++;
      $display("FAIL mid_load_reset: loaded=%b rdy=%b rst=%b want 0 0 1", loaded, bus.host_ready, bus.cpu_reset);
    end
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (bus.cpu_reset !== 1'b1 || cycle_count !== 32'd0) begin
        bad++;
        $display("FAIL run_unloaded +%0d: cpu_reset=%b cyc=%0d want 1 0", k, bus.cpu_reset, cycle_count);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_short_load();
    test_halt();
    test_hata();
    test_bad_pc();
    test_watchdog();
    test_load_wins();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
